waveram_arbiter: RTL and testbench

WAVERAM_ARBITER -- requirements
Module: waveram_arbiter

---
 rtl/waveram_arbiter_if.sv | 45 ++++
 rtl/waveram_arbiter.sv | 129 ++++++++++++
 tb/tb_waveram_arbiter.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/waveram_arbiter_if.sv
// Wave RAM arbiter bus bundle: voice read ports, host write port and RAM port.
// The slave modport is the arbiter's view; the master modport is the
// surrounding system (voices, host loader and RAM).
interface waveram_arbiter_if #(
    parameter int NUM_VOICES = 4,
    parameter int ADDR_WIDTH = 13,
    parameter int DATA_WIDTH = 8
);
    // voice read side
    logic [NUM_VOICES-1:0]            i_voice_req;
    logic [NUM_VOICES*ADDR_WIDTH-1:0] i_voice_addr;
    logic [NUM_VOICES-1:0]            o_voice_grant;
    logic [NUM_VOICES-1:0]            o_voice_valid;
    logic [DATA_WIDTH-1:0]            o_voice_data;

    // host wavetable load side
    logic                             i_host_wr_req;
    logic [ADDR_WIDTH-1:0]            i_host_wr_addr;
    logic [DATA_WIDTH-1:0]            i_host_wr_data;
    logic                             o_host_wr_ack;

    // synchronous RAM side
    logic [ADDR_WIDTH-1:0]            o_ram_addr;
    logic                             o_ram_we;
    logic [DATA_WIDTH-1:0]            o_ram_wdata;
    logic [DATA_WIDTH-1:0]            i_ram_rdata;

    modport slave (
        input  i_voice_req, i_voice_addr,
        output o_voice_grant, o_voice_valid, o_voice_data,
        input  i_host_wr_req, i_host_wr_addr, i_host_wr_data,
        output o_host_wr_ack,
        output o_ram_addr, o_ram_we, o_ram_wdata,
        input  i_ram_rdata
    );

    modport master (
        output i_voice_req, i_voice_addr,
        input  o_voice_grant, o_voice_valid, o_voice_data,
        output i_host_wr_req, i_host_wr_addr, i_host_wr_data,
        input  o_host_wr_ack,
        input  o_ram_addr, o_ram_we, o_ram_wdata,
        output i_ram_rdata
    );
endinterface

// File: rtl/waveram_arbiter.sv
// Wave RAM arbiter: shares one synchronous wave RAM between NUM_VOICES
// oscillator readers (round-robin) and a host wavetable loader (priority,
// with a fairness flag so a stream of host writes cannot starve voices).
// One access issued per cycle; read data returns to the granted voice
// three cycles after its request was evaluated.
module waveram_arbiter #(
    parameter int NUM_VOICES = 4,
    parameter int ADDR_WIDTH = 13,
    parameter int DATA_WIDTH = 8
) (
    input  logic               i_clock,
    input  logic               i_reset_n,
    waveram_arbiter_if.slave   bus
);

    localparam int PTR_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

    // issue stage registers (visible the cycle after arbitration)
    logic [NUM_VOICES-1:0] grant_q, grant_d;
    logic                  ack_q, ack_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  we_q, we_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

    // arbitration state
    logic [PTR_W-1:0]      ptr_q, ptr_d;
    logic                  host_last_q, host_last_d;

    // read return pipeline: RAM cycle, then registered data stage
    logic [NUM_VOICES-1:0] valid_p1_q;
    logic [NUM_VOICES-1:0] valid_q;
    logic [DATA_WIDTH-1:0] data_q;

    // arbitration intermediates
    logic [NUM_VOICES-1:0] voice_eff;
    logic                  host_eff;
    logic                  rr_found;
    logic [PTR_W-1:0]      rr_idx;
    logic [PTR_W-1:0]      cand;
    logic                  host_wins;

    // Requesters currently being served are masked so a held request is not
    // granted twice; round-robin search starts one past the last voice granted.
    always_comb begin
        voice_eff = bus.i_voice_req & ~grant_q;
        host_eff  = bus.i_host_wr_req & ~ack_q;
        rr_found  = 1'b0;
        rr_idx    = ptr_q;
        cand      = '0;
        for (int unsigned off = 1; off <= NUM_VOICES; off++) begin
            cand = PTR_W'((32'(ptr_q) + off) % NUM_VOICES);
            if (!rr_found && voice_eff[cand]) begin
                rr_found = 1'b1;
                rr_idx   = cand;
            end
        end
        // host yields once to any waiting voice right after a host write
        host_wins = host_eff && !(host_last_q && rr_found);
    end

    // Next-state selection for the single access issued this cycle.
    always_comb begin
        grant_d     = '0;
        ack_d       = 1'b0;
        we_d        = 1'b0;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        ptr_d       = ptr_q;
        host_last_d = host_last_q;
        if (host_wins) begin
            ack_d       = 1'b1;
            we_d        = 1'b1;
            addr_d      = bus.i_host_wr_addr;
            wdata_d     = bus.i_host_wr_data;
            host_last_d = 1'b1;
        end else if (rr_found) begin
            grant_d[rr_idx] = 1'b1;
            addr_d          = bus.i_voice_addr[int'(rr_idx)*ADDR_WIDTH +: ADDR_WIDTH];
            ptr_d           = rr_idx;
            host_last_d     = 1'b0;
        end
    end

    // Issue stage and arbitration state; reset restarts the search at voice 0.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            grant_q     <= '0;
            ack_q       <= 1'b0;
            addr_q      <= '0;
            we_q        <= 1'b0;
            wdata_q     <= '0;
            ptr_q       <= PTR_W'(NUM_VOICES - 1);
            host_last_q <= 1'b0;
        end else begin
            grant_q     <= grant_d;
            ack_q       <= ack_d;
            addr_q      <= addr_d;
            we_q        <= we_d;
            wdata_q     <= wdata_d;
            ptr_q       <= ptr_d;
            host_last_q <= host_last_d;
        end
    end

    // Read return: track grants through the RAM latency, capture data and
    // pulse valid for the owning voice; reset drops anything in flight.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            valid_p1_q <= '0;
            valid_q    <= '0;
            data_q     <= '0;
        end else begin
            valid_p1_q <= grant_q;
            valid_q    <= valid_p1_q;
            if (|valid_p1_q) begin
                data_q <= bus.i_ram_rdata;
            end
        end
    end

    assign bus.o_voice_grant = grant_q;
    assign bus.o_voice_valid = valid_q;
    assign bus.o_voice_data  = data_q;
    assign bus.o_host_wr_ack = ack_q;
    assign bus.o_ram_addr    = addr_q;
    assign bus.o_ram_we      = we_q;
    assign bus.o_ram_wdata   = wdata_q;

endmodule

// File: tb/tb_waveram_arbiter.sv
// Directed bench for waveram_arbiter with a synchronous RAM model.
module tb_waveram_arbiter;

    localparam int NV = 4;
    localparam int AW = 13;
    localparam int DW = 8;

    logic clk;
    logic rst_n;

    int n_total;
    int n_bad;

    // RAM model backdoor for preloading contents
    logic          pre_we;
    logic [AW-1:0] pre_addr;
    logic [DW-1:0] pre_data;
    logic [DW-1:0] mem [0:(1<<AW)-1];

    waveram_arbiter_if #(.NUM_VOICES(NV), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    waveram_arbiter #(.NUM_VOICES(NV), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .i_clock   (clk),
        .i_reset_n (rst_n),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // synchronous RAM: read data one cycle after address
    always @(posedge clk) begin
        if (pre_we)
            mem[pre_addr] <= pre_data;
        else if (bus.o_ram_we)
            mem[bus.o_ram_addr] <= bus.o_ram_wdata;
        bus.i_ram_rdata <= mem[bus.o_ram_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_vaddr(input int k, input logic [AW-1:0] a);
        bus.i_voice_addr[k*AW +: AW] = a;
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
        pre_we   = 1'b1;
        pre_addr = a;
        pre_data = d;
        step();
        pre_we   = 1'b0;
    endtask

    task automatic clear_inputs();
        bus.i_voice_req    = '0;
        bus.i_voice_addr   = '0;
        bus.i_host_wr_req  = 1'b0;
        bus.i_host_wr_addr = '0;
        bus.i_host_wr_data = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_grant"}, 32'(bus.o_voice_grant), 32'h0);
        check({tag, "_valid"}, 32'(bus.o_voice_valid), 32'h0);
        check({tag, "_ack"},   32'(bus.o_host_wr_ack), 32'h0);
        check({tag, "_we"},    32'(bus.o_ram_we),      32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        n_total = 0;
        n_bad   = 0;
        pre_we  = 1'b0;
        pre_addr = '0;
        pre_data = '0;
        rst_n   = 1'b0;
        clear_inputs();
        step();
        step();

        // reset state
        check_idle_outputs("rst");
        check("rst_addr",  32'(bus.o_ram_addr),  32'h0);
        check("rst_wdata", 32'(bus.o_ram_wdata), 32'h0);
        check("rst_data",  32'(bus.o_voice_data), 32'h0);

        preload(13'h0105, 8'h5A);
        for (int k = 0; k < NV; k++) preload(13'(16 + k), 8'(8'hA0 + k));
        preload(13'h0200, 8'h11);
        preload(13'h0201, 8'h22);
        rst_n = 1'b1;

        // single voice 2 read
        bus.i_voice_req = 4'b0100;
        set_vaddr(2, 13'h0105);
        step();
        check("v2_grant", 32'(bus.o_voice_grant), 32'h4);
        check("v2_addr",  32'(bus.o_ram_addr),    32'h0105);
        check("v2_we",    32'(bus.o_ram_we),      32'h0);
        check("v2_valid_t1", 32'(bus.o_voice_valid), 32'h0);
        bus.i_voice_req = '0;
        step();
        check("v2_grant_t2", 32'(bus.o_voice_grant), 32'h0);
        check("v2_valid_t2", 32'(bus.o_voice_valid), 32'h0);
        step();
        check("v2_valid", 32'(bus.o_voice_valid), 32'h4);
        check("v2_data",  32'(bus.o_voice_data),  32'h5A);
        step();
        check("v2_valid_off", 32'(bus.o_voice_valid), 32'h0);
        check("v2_data_hold", 32'(bus.o_voice_data),  32'h5A);
        check("idle_addr_hold", 32'(bus.o_ram_addr),  32'h0105);
        check_idle_outputs("idle");

        // all voices continuously requesting: round-robin from voice 0
        do_reset();
        for (int k = 0; k < NV; k++) set_vaddr(k, 13'(16 + k));
        bus.i_voice_req = 4'b1111;
        for (int j = 0; j <= 6; j++) begin
            step();
            check("rr_grant", 32'(bus.o_voice_grant), (j <= 4) ? (32'h1 << (j % 4)) : 32'h0);
            if (j >= 2) begin
                check("rr_valid", 32'(bus.o_voice_valid), 32'h1 << ((j - 2) % 4));
                check("rr_data",  32'(bus.o_voice_data),  32'hA0 + 32'((j - 2) % 4));
            end else begin
                check("rr_valid0", 32'(bus.o_voice_valid), 32'h0);
            end
            if (j == 4) bus.i_voice_req = '0;
        end

        // host write held alongside voices 0 and 1: host, v0, host, v1
        do_reset();
        set_vaddr(0, 13'h0400);
        set_vaddr(1, 13'h0401);
        bus.i_voice_req    = 4'b0011;
        bus.i_host_wr_req  = 1'b1;
        bus.i_host_wr_addr = 13'h0300;
        bus.i_host_wr_data = 8'h77;
        step();
        check("hv_ack0",   32'(bus.o_host_wr_ack), 32'h1);
        check("hv_we0",    32'(bus.o_ram_we),      32'h1);
        check("hv_addr0",  32'(bus.o_ram_addr),    32'h0300);
        check("hv_wdata0", 32'(bus.o_ram_wdata),   32'h77);
        check("hv_grant0", 32'(bus.o_voice_grant), 32'h0);
        bus.i_host_wr_addr = 13'h0301;
        bus.i_host_wr_data = 8'h78;
        step();
        check("hv_grant1", 32'(bus.o_voice_grant), 32'h1);
        check("hv_ack1",   32'(bus.o_host_wr_ack), 32'h0);
        check("hv_we1",    32'(bus.o_ram_we),      32'h0);
        check("hv_addr1",  32'(bus.o_ram_addr),    32'h0400);
        bus.i_voice_req = 4'b0010;
        step();
        check("hv_ack2",   32'(bus.o_host_wr_ack), 32'h1);
        check("hv_we2",    32'(bus.o_ram_we),      32'h1);
        check("hv_addr2",  32'(bus.o_ram_addr),    32'h0301);
        check("hv_grant2", 32'(bus.o_voice_grant), 32'h0);
        bus.i_host_wr_req = 1'b0;
        step();
        check("hv_grant3", 32'(bus.o_voice_grant), 32'h2);
        check("hv_we3",    32'(bus.o_ram_we),      32'h0);
        check("hv_addr3",  32'(bus.o_ram_addr),    32'h0401);
        bus.i_voice_req = '0;
        step();

        // host write to 0x1FFF, voice 0 reads it on the next cycle
        bus.i_host_wr_req  = 1'b1;
        bus.i_host_wr_addr = 13'h1FFF;
        bus.i_host_wr_data = 8'hC3;
        step();
        check("raw_ack",  32'(bus.o_host_wr_ack), 32'h1);
        check("raw_addr", 32'(bus.o_ram_addr),    32'h1FFF);
        bus.i_host_wr_req = 1'b0;
        set_vaddr(0, 13'h1FFF);
        bus.i_voice_req = 4'b0001;
        step();
        check("raw_grant", 32'(bus.o_voice_grant), 32'h1);
        check("raw_raddr", 32'(bus.o_ram_addr),    32'h1FFF);
        bus.i_voice_req = '0;
        step();
        step();
        check("raw_valid", 32'(bus.o_voice_valid), 32'h1);
        check("raw_data",  32'(bus.o_voice_data),  32'hC3);

        // fairness flag persists across an idle cycle after a host write
        bus.i_host_wr_req  = 1'b1;
        bus.i_host_wr_addr = 13'h0500;
        bus.i_host_wr_data = 8'h01;
        step();
        check("fair_ack0", 32'(bus.o_host_wr_ack), 32'h1);
        bus.i_host_wr_req = 1'b0;
        step();
        check_idle_outputs("fair_idle");
        bus.i_host_wr_req  = 1'b1;
        bus.i_host_wr_addr = 13'h0501;
        set_vaddr(2, 13'h0105);
        bus.i_voice_req = 4'b0100;
        step();
        check("fair_grant", 32'(bus.o_voice_grant), 32'h4);
        check("fair_ack1",  32'(bus.o_host_wr_ack), 32'h0);
        bus.i_voice_req = '0;
        step();
        check("fair_ack2",  32'(bus.o_host_wr_ack), 32'h1);
        check("fair_addr2", 32'(bus.o_ram_addr),    32'h0501);
        bus.i_host_wr_req = 1'b0;
        step();

        // reset mid-stream with two reads in flight
        set_vaddr(0, 13'h0200);
        set_vaddr(1, 13'h0201);
        bus.i_voice_req = 4'b0011;
        step();
        check("mid_grant0", 32'(bus.o_voice_grant), 32'h1);
        bus.i_voice_req = 4'b0010;
        step();
        check("mid_grant1", 32'(bus.o_voice_grant), 32'h2);
        bus.i_voice_req = '0;
        rst_n = 1'b0;
        #1;
        check_idle_outputs("mid_rst");
        check("mid_rst_addr", 32'(bus.o_ram_addr),   32'h0);
        check("mid_rst_data", 32'(bus.o_voice_data), 32'h0);
        step();
        rst_n = 1'b1;
        for (int j = 0; j < 3; j++) begin
            step();
            check("post_rst_valid", 32'(bus.o_voice_valid), 32'h0);
        end
        bus.i_voice_req = 4'b1111;
        step();
        check("post_rst_grant", 32'(bus.o_voice_grant), 32'h1);
        check("post_rst_addr",  32'(bus.o_ram_addr),    32'h0200);
        bus.i_voice_req = '0;
        step();
        step();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
